// File: rtl/serial_byte_deframer.sv
// Bit-serial deframer: hunts for a bit-aligned sync byte, then forwards a fixed
// number of MSB-first payload bytes through a 2-entry output FIFO.
module serial_byte_deframer #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         PAYLOAD_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       out_ready,
  input  logic       clr_ovf,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       locked,
  output logic       overflow,
  output logic [7:0] frame_cnt
);

  localparam logic [0:0] ST_HUNT    = 1'b0;
  localparam logic [0:0] ST_PAYLOAD = 1'b1;
  localparam logic [7:0] LAST_BYTE  = 8'(PAYLOAD_LEN - 1);

  logic [0:0] r_state;
  logic       r_locked;
  logic [7:0] r_hunt;
  logic [7:0] r_acc;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_byte_cnt;
  logic [7:0] r_frame_cnt;
  logic       r_ovf;

  logic [7:0] r_mem [0:1];
  logic       r_rd_ptr;
  logic       r_wr_ptr;
  logic [1:0] r_count;

  logic [7:0] w_hunt_next;
  logic [7:0] w_byte_next;
  logic       w_pop;
  logic       w_full;
  logic       w_push_req;
  logic       w_push;
  logic       w_drop;
  logic       w_frame_done;

  assign w_hunt_next  = {r_hunt[6:0], bit_in};
  assign w_byte_next  = {r_acc[6:0], bit_in};
  assign w_pop        = (r_count != 2'd0) && out_ready;
  assign w_full       = (r_count == 2'd2);
  assign w_push_req   = bit_valid && (r_state == ST_PAYLOAD) && (r_bit_cnt == 3'd7);
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign w_push       = w_push_req && (!w_full || w_pop);
  assign w_drop       = w_push_req && w_full && !w_pop;
  assign w_frame_done = w_push && (r_byte_cnt == LAST_BYTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_HUNT;
      r_locked    <= 1'b0;
      r_hunt      <= 8'd0;
      r_acc       <= 8'd0;
      r_bit_cnt   <= 3'd0;
      r_byte_cnt  <= 8'd0;
      r_frame_cnt <= 8'd0;
      r_ovf       <= 1'b0;
    end else begin
      if (bit_valid) begin
        if (r_state == ST_HUNT) begin
          r_hunt <= w_hunt_next;
          if (w_hunt_next == SYNC_BYTE) begin
            r_state    <= ST_PAYLOAD;
            r_locked   <= 1'b1;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 8'd0;
          end
        end else begin
          r_acc     <= w_byte_next;
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_push) r_byte_cnt <= r_byte_cnt + 8'd1;
          if (w_frame_done) r_frame_cnt <= r_frame_cnt + 8'd1;
          // Frame end and a dropped byte both resynchronise from scratch.
          if (w_frame_done || w_drop) begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
            r_hunt   <= 8'd0;
          end
        end
      end
      if (w_drop) r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= 8'd0;
      r_mem[1] <= 8'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_byte_next;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign out_data  = r_mem[r_rd_ptr];
  assign out_valid = (r_count != 2'd0);
  assign locked    = r_locked;
  assign overflow  = r_ovf;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_serial_byte_deframer.sv
// Randomised self-checking bench for serial_byte_deframer with a bit-stream
// parsing reference model.
module tb_serial_byte_deframer;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         LEN  = 4;

  logic       clk = 1'b0;
  logic       rst_n, bit_in, bit_valid, out_ready, clr_ovf;
  logic [7:0] out_data;
  logic       out_valid, locked, overflow;
  logic [7:0] frame_cnt;

  int errors = 0;
  int checks = 0;
  int gap_max = 0;
  int exp_frames;
  bit stim[$];
  byte unsigned exp_q[$];
  byte unsigned got_q[$];
  byte unsigned con_q[$];

  serial_byte_deframer #(.SYNC_BYTE(SYNC), .PAYLOAD_LEN(LEN)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .out_ready(out_ready), .clr_ovf(clr_ovf), .out_data(out_data),
    .out_valid(out_valid), .locked(locked), .overflow(overflow),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Record every byte handed downstream (valid and ready at the coming edge).
  always @(negedge clk)
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
      got_q.push_back(out_data);

  // Reference: scan the bit stream for the sync pattern (hunt register starts
  // at zero after reset and after every frame), then slice LEN whole bytes.
  function automatic void run_model();
    int n, i, start, w, idx, v;
    bit found;
    n = stim.size();
    i = 0;
    start = 0;
    exp_q.delete();
    exp_frames = 0;
    while (i < n) begin
      found = 0;
      while (i < n && !found) begin
        w = 0;
        for (int k = 0; k < 8; k++) begin
          idx = i - 7 + k;
          w = w * 2 + ((idx >= start) ? int'(stim[idx]) : 0);
        end
        if (w == int'(SYNC)) found = 1;
        i++;
      end
      if (!found) return;
      for (int b = 0; b < LEN; b++) begin
        if (i + 8 > n) return;
        v = 0;
        for (int k = 0; k < 8; k++) v = v * 2 + int'(stim[i + k]);
        exp_q.push_back(8'(v));
        i += 8;
      end
      exp_frames++;
      start = i;
    end
  endfunction

  function automatic int qdiff(input byte unsigned a[$], input byte unsigned b[$]);
    int d;
    d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int k = 0; k < a.size() && k < b.size(); k++)
      if (a[k] != b[k]) d++;
    return d;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    if (gap_max > 0) idle($urandom_range(0, gap_max));
    bit_in = b;
    bit_valid = 1'b1;
    stim.push_back(b);
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    bit_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    clr_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stim.delete();
    got_q.delete();
    gap_max = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    out_ready = 1'b0;
    clr_ovf = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (frame_cnt !== 8'h00) begin errors++; $display("FAIL reset_frame_cnt got=%h exp=00", frame_cnt); end
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    send_byte(SYNC);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL basic_locked_on_sync got=%b exp=1", locked); end
    send_byte(8'h11);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin errors++; $display("FAIL basic_latency got=%b/%h exp=1/11", out_valid, out_data); end
    send_byte(8'h22);
    send_byte(8'h33);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL basic_locked_mid got=%b exp=1", locked); end
    send_byte(8'h44);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL basic_unlock_at_end got=%b exp=0", locked); end
    idle(4);
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL basic_frame_cnt got=%0d exp=1", frame_cnt); end
    con_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    checks++; if (qdiff(got_q, con_q) != 0) begin errors++; $display("FAIL basic_bytes got_n=%0d exp_n=4 first=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00); end
    run_model();
    checks++; if (qdiff(got_q, exp_q) != 0) begin errors++; $display("FAIL basic_model got_n=%0d exp_n=%0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_byte(SYNC);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL ovf_locked got=%b exp=0", locked); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL ovf_frame_cnt got=%0d exp=0", frame_cnt); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin errors++; $display("FAIL ovf_head_stable got=%b/%h exp=1/11", out_valid, out_data); end
    out_ready = 1'b1;
    idle(4);
    con_q = '{8'h11, 8'h22};
    checks++; if (qdiff(got_q, con_q) != 0) begin errors++; $display("FAIL ovf_drain got_n=%0d exp_n=2", got_q.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b exp=0", out_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    // Drop on the same edge as a clear request: the set must win.
    out_ready = 1'b0;
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h02);
    clr_ovf = 1'b1;
    send_byte(8'h03);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
    idle(1);
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear_after got=%b exp=0", overflow); end
    out_ready = 1'b1;
    idle(4);
  endtask

  task automatic test_gapped();
    logic l_before;
    logic [7:0] f_before;
    do_reset();
    out_ready = 1'b1;
    con_q.delete();
    gap_max = 3;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    for (int f = 0; f < 3; f++) begin
      send_byte(SYNC);
      for (int b = 0; b < LEN; b++) begin
        logic [7:0] v;
        v = 8'($urandom);
        con_q.push_back(v);
        if (f == 1 && b == 1) begin
          for (int i = 7; i >= 4; i--) send_bit(v[i]);
          l_before = locked;
          f_before = frame_cnt;
          idle(6);
          checks++; if (locked !== 1'b1 || l_before !== 1'b1) begin errors++; $display("FAIL gap_idle_locked got=%b exp=1", locked); end
          checks++; if (frame_cnt !== f_before || frame_cnt !== 8'd1) begin errors++; $display("FAIL gap_idle_frame_cnt got=%0d exp=1", frame_cnt); end
          for (int i = 3; i >= 0; i--) send_bit(v[i]);
        end else begin
          send_byte(v);
        end
      end
    end
    gap_max = 0;
    idle(4);
    checks++; if (qdiff(got_q, con_q) != 0) begin errors++; $display("FAIL gap_bytes got_n=%0d exp_n=%0d", got_q.size(), con_q.size()); end
    run_model();
    checks++; if (qdiff(got_q, exp_q) != 0) begin errors++; $display("FAIL gap_model got_n=%0d exp_n=%0d", got_q.size(), exp_q.size()); end
    checks++; if (frame_cnt !== 8'(exp_frames)) begin errors++; $display("FAIL gap_frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_double_sync();
    do_reset();
    out_ready = 1'b1;
    send_byte(SYNC);
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    idle(4);
    con_q = '{SYNC, 8'h01, 8'h02, 8'h03};
    checks++; if (qdiff(got_q, con_q) != 0) begin errors++; $display("FAIL dsync_bytes got_n=%0d exp_n=4", got_q.size()); end
    checks++; if (frame_cnt !== 8'd1 || locked !== 1'b0) begin errors++; $display("FAIL dsync_frame got=%0d/%b exp=1/0", frame_cnt, locked); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    send_byte(SYNC);
    for (int b = 0; b < LEN; b++) send_byte(8'(b + 1));
    idle(3);
    out_ready = 1'b0;
    send_byte(SYNC);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(SYNC);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    checks++; if (out_valid !== 1'b1 || locked !== 1'b1 || overflow !== 1'b1 || frame_cnt !== 8'd1) begin
      errors++; $display("FAIL rstmid_pre got=%b/%b/%b/%0d exp=1/1/1/1", out_valid, locked, overflow, frame_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL rstmid_fifo got=%b/%h exp=0/00", out_valid, out_data); end
    checks++; if (locked !== 1'b0 || overflow !== 1'b0 || frame_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_ctrl got=%b/%b/%0d exp=0/0/0", locked, overflow, frame_cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stim.delete();
    got_q.delete();
    out_ready = 1'b1;
    send_byte(SYNC);
    send_byte(8'h5A);
    send_byte(8'hC3);
    send_byte(8'h0F);
    send_byte(8'hF0);
    idle(4);
    con_q = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
    checks++; if (qdiff(got_q, con_q) != 0) begin errors++; $display("FAIL rstmid_fresh got_n=%0d exp_n=4", got_q.size()); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL rstmid_frame_cnt got=%0d exp=1", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int f = 0; f < 256; f++) begin
      send_byte(SYNC);
      for (int b = 0; b < LEN; b++) send_byte(8'($urandom));
      if (f == 254) begin
        checks++; if (frame_cnt !== 8'd255) begin errors++; $display("FAIL b2b_cnt_255 got=%0d exp=255", frame_cnt); end
      end
    end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL b2b_wrap got=%0d exp=0", frame_cnt); end
    idle(4);
    run_model();
    checks++; if (qdiff(got_q, exp_q) != 0 || exp_frames != 256) begin errors++; $display("FAIL b2b_model got_n=%0d exp_n=%0d", got_q.size(), exp_q.size()); end
    // Fill the FIFO, then release the head on the edge that pushes a third byte.
    got_q.delete();
    out_ready = 1'b0;
    send_byte(SYNC);
    send_byte(8'h11);
    send_byte(8'h22);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h33 >> i));
    out_ready = 1'b1;
    send_bit(1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf got=%b exp=0", overflow); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h22 || locked !== 1'b1) begin errors++; $display("FAIL full_pushpop_head got=%b/%h/%b exp=1/22/1", out_valid, out_data, locked); end
    send_byte(8'h44);
    idle(4);
    con_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    checks++; if (qdiff(got_q, con_q) != 0) begin errors++; $display("FAIL full_pushpop_bytes got_n=%0d exp_n=4", got_q.size()); end
    checks++; if (frame_cnt !== 8'd1 || overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_frame got=%0d/%b exp=1/0", frame_cnt, overflow); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_gapped();
    test_double_sync();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
